// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status seen by the controller and the
// stall/flush/status signals it returns to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             ex_mdu_start;
  logic             mdu_done;
  logic             imem_rsp_valid;
  logic             stall_pc;
  logic             stall_if_id;
  logic             flush_if_id;
  logic             stall_id_ex;
  logic             flush_id_ex;
  logic [1:0]       ctrl_state;
  logic             mdu_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_is_load, ex_rd, ex_redirect, ex_mdu_start,
    output mdu_done, imem_rsp_valid,
    input  stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
    input  ctrl_state, mdu_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_is_load, ex_rd, ex_redirect, ex_mdu_start,
    input  mdu_done, imem_rsp_valid,
    output stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
    output ctrl_state, mdu_timeout_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core with MDU watchdog.
// Define PIPE_HAZARD_PERF_EN to build the stall/redirect performance counters.
//
// state       | meaning
// ST_RUN      | normal issue; hazards resolved combinationally
// ST_MDU_WAIT | multi-cycle MDU op in flight, front of pipe frozen
// ST_HALT     | MDU watchdog expired, pipe frozen until reset
module pipe_hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WD_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  // Loaded on MDU issue; HALT when a non-done wait cycle sees zero, giving
  // MDU_TIMEOUT-1 wait cycles (MDU_TIMEOUT stall cycles including the issue).
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MDU_TIMEOUT - 2);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            err, err_nxt;
  logic            lu;
  logic            stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;

  assign lu = bus.id_valid && bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
              ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wd_cnt_nxt  = wd_cnt;
    err_nxt     = err;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst_n) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (bus.ex_mdu_start && !bus.mdu_done) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            state_nxt   = ST_MDU_WAIT;
            wd_cnt_nxt  = WD_LOAD;
          end else if (bus.ex_mdu_start) begin
            // single-cycle MDU result: nothing to hold
          end else if (lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (!bus.imem_rsp_valid) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (bus.mdu_done) begin
            state_nxt = ST_RUN;
          end else begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            if (wd_cnt == '0) begin
              state_nxt = ST_HALT;
              err_nxt   = 1'b1;
            end else begin
              wd_cnt_nxt = wd_cnt - WD_W'(1);
            end
          end
        end
        ST_HALT: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign bus.stall_pc        = stall_pc;
  assign bus.stall_if_id     = stall_if_id;
  assign bus.flush_if_id     = flush_if_id;
  assign bus.stall_id_ex     = stall_id_ex;
  assign bus.flush_id_ex     = flush_id_ex;
  assign bus.ctrl_state      = state;
  assign bus.mdu_timeout_err = err;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == ST_RUN) && bus.ex_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_events = flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CW      = 32;

  typedef struct {
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ex_valid;
    logic       ld;
    logic [4:0] rd;
    logic       redir;
    logic       start;
    logic       done;
    logic       imem;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [4:0]  ctl;   // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex}
    logic [1:0]  st;
    logic        err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MDU_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: 0 run, 1 waiting on MDU, 2 halted.
  int            m_mode   = 0;
  int            m_waited = 0;
  bit            m_err    = 1'b0;
  logic [CW-1:0] m_sc     = '0;
  logic [CW-1:0] m_fe     = '0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, id_valid: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0,
          ex_valid: 1'b0, ld: 1'b0, rd: 5'd0, redir: 1'b0, start: 1'b0,
          done: 1'b0, imem: 1'b1};
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, sp, sif, fif, sie, fie;
    @(negedge clk);
    rst_n              = s.rst_n;
    bus.id_valid       = s.id_valid;
    bus.id_rs1         = s.rs1;
    bus.id_rs2         = s.rs2;
    bus.id_uses_rs1    = s.u1;
    bus.id_uses_rs2    = s.u2;
    bus.ex_valid       = s.ex_valid;
    bus.ex_is_load     = s.ld;
    bus.ex_rd          = s.rd;
    bus.ex_redirect    = s.redir;
    bus.ex_mdu_start   = s.start;
    bus.mdu_done       = s.done;
    bus.imem_rsp_valid = s.imem;

    e.cyc = cyc;
    e.st  = 2'(m_mode);
    e.err = m_err;
    e.sc  = m_sc;
    e.fe  = m_fe;
    {sp, sif, fif, sie, fie} = 5'b0;
    lu = s.id_valid && s.ex_valid && s.ld && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));

    if (!s.rst_n) begin
      fif = 1; fie = 1;
      m_mode = 0; m_waited = 0; m_err = 0; m_sc = '0; m_fe = '0;
    end else begin
      if (m_mode == 0) begin
        if (s.redir) begin
          fif = 1; fie = 1;
          if (m_fe != '1) m_fe = m_fe + 1;
        end else if (s.start && !s.done) begin
          sp = 1; sif = 1; sie = 1;
          m_mode = 1; m_waited = 0;
        end else if (s.start) begin
        end else if (lu) begin
          sp = 1; sif = 1; fie = 1;
        end else if (!s.imem) begin
          sp = 1; fif = 1;
        end
      end else if (m_mode == 1) begin
        if (s.done) m_mode = 0;
        else begin
          sp = 1; sif = 1; sie = 1;
          m_waited++;
          if (m_waited == TIMEOUT - 1) begin
            m_mode = 2; m_err = 1;
          end
        end
      end else begin
        sp = 1; sif = 1; sie = 1;
      end
      if (sp && m_sc != '1) m_sc = m_sc + 1;
    end
    e.ctl = {sp, sif, fif, sie, fie};
    sb.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input int c, input logic [CW-1:0] got,
                     input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, c, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle once inputs settle after negedge.
  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctl", e.cyc, CW'({bus.stall_pc, bus.stall_if_id, bus.flush_if_id,
                             bus.stall_id_ex, bus.flush_id_ex}), CW'(e.ctl));
      chk("ctrl_state", e.cyc, CW'(bus.ctrl_state), CW'(e.st));
      chk("mdu_timeout_err", e.cyc, CW'(bus.mdu_timeout_err), CW'(e.err));
`ifdef PIPE_HAZARD_PERF_EN
      chk("stall_cycles", e.cyc, bus.stall_cycles, e.sc);
      chk("flush_events", e.cyc, bus.flush_events, e.fe);
`else
      chk("stall_cycles", e.cyc, bus.stall_cycles, '0);
      chk("flush_events", e.cyc, bus.flush_events, '0);
`endif
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst_n = 1'b0;
    step(s); step(s);
    step(idle());

    // load-use on rs2, then the load has moved on
    s = idle(); s.ex_valid = 1; s.ld = 1; s.rd = 5'd5;
    s.id_valid = 1; s.rs2 = 5'd5; s.u2 = 1;
    step(s);
    s.ld = 0; step(s);
    // same pattern with x0 destination
    s.ld = 1; s.rd = 5'd0; s.rs2 = 5'd0; step(s);

    // redirect beats concurrent load-use
    s = idle(); s.ex_valid = 1; s.ld = 1; s.rd = 5'd7;
    s.id_valid = 1; s.rs1 = 5'd7; s.u1 = 1; s.redir = 1;
    step(s);
    step(idle());

    // MDU op with done five cycles after start
    s = idle(); s.start = 1; step(s);
    repeat (4) step(idle());
    s = idle(); s.done = 1; step(s);
    step(idle());

    // watchdog expiry, then one reset cycle
    s = idle(); s.start = 1; step(s);
    repeat (10) step(idle());
    s = idle(); s.rst_n = 0; step(s);
    step(idle());

    // done arriving on the last allowed wait cycle
    s = idle(); s.start = 1; step(s);
    repeat (TIMEOUT - 2) step(idle());
    s = idle(); s.done = 1; step(s);
    step(idle());

    // three-cycle instruction-memory gap
    s = idle(); s.imem = 0;
    repeat (3) step(s);
    step(idle());

    // reset while waiting on the MDU
    s = idle(); s.start = 1; step(s);
    step(idle());
    s = idle(); s.rst_n = 0; step(s);
    step(idle());

    for (int i = 0; i < 3000; i++) begin
      s.rst_n    = (m_mode == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 79) != 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.u1       = 1'($urandom_range(0, 1));
      s.u2       = 1'($urandom_range(0, 1));
      s.ex_valid = ($urandom_range(0, 3) != 0);
      s.ld       = 1'($urandom_range(0, 1));
      s.rd       = 5'($urandom_range(0, 3));
      s.redir    = ($urandom_range(0, 7) == 0);
      s.start    = ($urandom_range(0, 9) == 0);
      s.done     = ($urandom_range(0, 4) == 0);
      s.imem     = ($urandom_range(0, 4) != 0);
      step(s);
    end
    step(idle());

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the single-issue 5-stage core. It drives hold and bubble controls for the PC register, the IF/ID pipeline register and the ID/EX pipeline register. It resolves four conditions:
- load-use hazards
- taken branch/jump redirects from EX
- multi-cycle MDU (mul/div) occupancy
- instruction-memory response gaps

It also contains a small FSM that tracks MDU waits and a watchdog that halts the pipe on a hung MDU.

Parameters:
- MDU_TIMEOUT, 64: maximum cycles spent in MDU_WAIT before halting; must be ≥2.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- ex_mdu_start  in  1  multi-cycle MDU op issued from EX this cycle.
- mdu_done  in  1  MDU result valid this cycle.
- imem_rsp_valid  in  1  instruction memory returned the fetched word this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID register.
- flush_if_id  out  1  load a NOP/zero into IF/ID.
- stall_id_ex  out  1  hold the ID/EX register.
- flush_id_ex  out  1  load a bubble into ID/EX.
- ctrl_state  out  2  FSM state: 0=RUN, 1=MDU_WAIT, 2=HALT.
- mdu_timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1 (optional feature).
- flush_events  out  CNT_W  count of redirects taken (optional feature).

Behaviour:
- Reset (rst_n=0, sampled at posedge):
  - State → RUN, watchdog counter → 0, mdu_timeout_err → 0, perf counters → 0.
  - While rst_n=0, outputs are forced to: flush_if_id=1, flush_id_ex=1, all stalls 0.
  - Reset mid-MDU_WAIT or in HALT returns to RUN on the next edge.
- All control outputs are combinational from the registered state and current inputs, so they act in the same cycle. State, watchdog and counters are registered.
- Load-use term: lu = id_valid & ex_valid & ex_is_load & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN outputs, applied by priority (first match wins):
  1. ex_redirect: flush_if_id=1, flush_id_ex=1, no stalls. ex_mdu_start in the same cycle is ignored (illegal combination; redirect wins).
  2. ex_mdu_start & !mdu_done: stall_pc=stall_if_id=stall_id_ex=1. Next state is MDU_WAIT and the watchdog is cleared.
  3. ex_mdu_start & mdu_done: single-cycle op, no stall, stay in RUN.
  4. lu: stall_pc=1, stall_if_id=1, flush_id_ex=1. Lasts exactly one cycle, because the load advances to MEM.
  5. !imem_rsp_valid: stall_pc=1, flush_if_id=1 (bubble into ID), ID/EX advances normally.
  6. Otherwise: all outputs 0.
- MDU_WAIT:
  - stall_pc=stall_if_id=stall_id_ex=1. ex_redirect and lu are ignored.
  - On mdu_done: all stalls drop in the same cycle and the next state is RUN.
  - Otherwise the watchdog increments. When it equals MDU_TIMEOUT-1 without mdu_done: next state HALT and mdu_timeout_err is set.
  - If mdu_done arrives on the timeout cycle, done wins: go to RUN, no error.
- HALT: stall_pc=stall_if_id=stall_id_ex=1 and flush_id_ex=0. Exit is by reset only.
- ctrl_state reflects the registered state.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with rst_n=1 & stall_pc=1.
  - flush_events increments on each RUN-state cycle with ex_redirect=1.
  - Both saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: ex load rd=5, id rs2=5 uses_rs2=1 → exactly one cycle of stall_pc=stall_if_id=flush_id_ex=1. Same case with ex_rd=0 → no stall.
- Redirect with a concurrent load-use → flush_if_id=flush_id_ex=1, stall_pc=0, ctrl_state stays 0. With PIPE_HAZARD_PERF_EN, flush_events=1.
- MDU op, mdu_done 5 cycles after start → stalls high for 5 cycles, ctrl_state=1 during the wait, stalls drop on the done cycle, then RUN.
- MDU_TIMEOUT=8 with no done → HALT after 8 stall cycles, mdu_timeout_err=1, stalls held. rst_n=0 for 1 cycle → RUN, err=0.
- imem_rsp_valid low for 3 cycles → stall_pc=flush_if_id=1 for 3 cycles, stall_id_ex=0.
- rst_n low while in MDU_WAIT → flush_if_id=flush_id_ex=1 during reset, ctrl_state=0 after the edge.
